// File: rtl/clock_divider_meter_pkg.sv
// Shared definitions for the clock divider meter: FSM state encoding and
// default sizing for the half-period counter.
package clock_divider_meter_pkg;

  // Measurement FSM states
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARM     = 2'd1,
    ST_MEASURE = 2'd2
  } state_e;

  // Default counter/result width
  localparam int CNT_W_DEFAULT = 32;

  // Default half-period length beyond which a timeout is declared
  localparam logic [31:0] MAX_COUNT_DEFAULT = 32'hFFFF_FFFE;

  // Default number of identical results in a row needed for lock
  localparam int LOCK_N_DEFAULT = 4;

endpackage : clock_divider_meter_pkg

// File: rtl/clock_divider_meter_sync_edge_detect.sv
// Two-flop synchronizer plus a third flop for edge detection. Any change of
// the asynchronous input (rising or falling) yields a one-cycle edge pulse.
// Reusable for any block that consumes an asynchronous level.
module sync_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic edge_pulse
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic sync3_q, sync3_d;

  // Shift the input one stage down the chain each clock
  always_comb begin
    sync1_d = async_in;
    sync2_d = sync1_q;
    sync3_d = sync2_q;
  end

  // Synchronizer and edge-detect flops, cleared asynchronously
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      sync3_q <= sync3_d;
    end
  end

  // Any difference between the last two synchronized samples is an edge
  assign edge_pulse = sync2_q ^ sync3_q;

endmodule : sync_edge_detect

// File: rtl/clock_divider_meter.sv
// Half-period meter for a slow square wave, counted in fast clk cycles.
// Each detected inClk edge closes one measurement and opens the next; the
// result is published on measCount with a one-cycle measValid pulse.
// Optional lock detection is built when CLOCK_DIVIDER_METER_LOCK_DETECT_EN
// is defined; otherwise locked is a constant 0.
module clock_divider_meter
  import clock_divider_meter_pkg::*;
#(
  parameter int               CNT_W     = CNT_W_DEFAULT,
  parameter logic [CNT_W-1:0] MAX_COUNT = CNT_W'(MAX_COUNT_DEFAULT),
  parameter int               LOCK_N    = LOCK_N_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inClk,
  input  logic             enable,
  output logic [CNT_W-1:0] measCount,
  output logic             measValid,
  output logic             timeout,
  output logic             locked
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // The counter must never reach all-ones, so MAX_COUNT has to stay below it
  if (MAX_COUNT >= {CNT_W{1'b1}}) begin : g_max_count_check
    $error("clock_divider_meter: MAX_COUNT must be below 2**CNT_W-1");
  end
  if (LOCK_N < 1) begin : g_lock_n_check
    $error("clock_divider_meter: LOCK_N must be at least 1");
  end

  state_e           state_q, state_d;
  logic [CNT_W-1:0] counter_q, counter_d;
  logic [CNT_W-1:0] meas_count_q, meas_count_d;
  logic             meas_valid_q, meas_valid_d;
  logic             timeout_q, timeout_d;
  logic             edge_s;
  logic             at_max_s;

  sync_edge_detect u_sync_edge_detect (
    .clk        (clk),
    .reset      (reset),
    .async_in   (inClk),
    .edge_pulse (edge_s)
  );

  assign at_max_s = (counter_q == MAX_COUNT);

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; dropping enable always returns to IDLE
  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_ARM;
        end
        ST_ARM: begin
          if (edge_s) begin
            state_d = ST_MEASURE;
          end else begin
            state_d = ST_ARM;
          end
        end
        ST_MEASURE: begin
          // An edge coinciding with MAX_COUNT is a normal measurement
          if (edge_s) begin
            state_d = ST_MEASURE;
          end else if (at_max_s) begin
            state_d = ST_ARM;
          end else begin
            state_d = ST_MEASURE;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Counter, result capture and timeout flag per state
  always_comb begin
    counter_d    = counter_q;
    meas_count_d = meas_count_q;
    meas_valid_d = 1'b0;
    timeout_d    = timeout_q;
    if (!enable) begin
      counter_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // Leaving IDLE starts a fresh session, so forget old timeouts
          counter_d = '0;
          timeout_d = 1'b0;
        end
        ST_ARM: begin
          // First edge only starts counting; the partial period is dropped
          if (edge_s) begin
            counter_d = CNT_ONE;
          end else begin
            counter_d = '0;
          end
        end
        ST_MEASURE: begin
          if (edge_s) begin
            meas_count_d = counter_q;
            meas_valid_d = 1'b1;
            counter_d    = CNT_ONE;
          end else if (at_max_s) begin
            timeout_d = 1'b1;
            counter_d = '0;
          end else begin
            counter_d = counter_q + CNT_ONE;
          end
        end
        default: begin
          counter_d = '0;
        end
      endcase
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      counter_q    <= '0;
      meas_count_q <= '0;
      meas_valid_q <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      counter_q    <= counter_d;
      meas_count_q <= meas_count_d;
      meas_valid_q <= meas_valid_d;
      timeout_q    <= timeout_d;
    end
  end

  assign measCount = meas_count_q;
  assign measValid = meas_valid_q;
  assign timeout   = timeout_q;

`ifdef CLOCK_DIVIDER_METER_LOCK_DETECT_EN
  localparam int                 MATCH_W     = $clog2(LOCK_N) + 1;
  localparam logic [MATCH_W-1:0] LOCK_TARGET = MATCH_W'(LOCK_N - 1);
  localparam logic [MATCH_W-1:0] MATCH_ONE   = MATCH_W'(1);

  logic [MATCH_W-1:0] match_q, match_d;
  logic               have_prev_q, have_prev_d;
  logic               locked_q, locked_d;
  logic               meas_evt_s;
  logic               clear_evt_s;

  // A result is produced exactly when MEASURE sees an edge while enabled
  assign meas_evt_s  = enable && (state_q == ST_MEASURE) && edge_s;
  // Timeout, IDLE or disable restart the run of equal results
  assign clear_evt_s = !enable || (state_q == ST_IDLE) ||
                       ((state_q == ST_MEASURE) && !edge_s && at_max_s);

  // Track consecutive equal results; lock when LOCK_N in a row agree
  always_comb begin
    match_d     = match_q;
    have_prev_d = have_prev_q;
    locked_d    = locked_q;
    if (clear_evt_s) begin
      match_d     = '0;
      have_prev_d = 1'b0;
      locked_d    = 1'b0;
    end else if (meas_evt_s) begin
      // Only results from the current session count as "previous"
      if (have_prev_q && (counter_q == meas_count_q)) begin
        if (match_q < LOCK_TARGET) begin
          match_d = match_q + MATCH_ONE;
        end else begin
          match_d = match_q;
        end
      end else begin
        match_d = '0;
      end
      have_prev_d = 1'b1;
      locked_d    = (match_d >= LOCK_TARGET);
    end else begin
      match_d = match_q;
    end
  end

  // Lock-detect registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      match_q     <= '0;
      have_prev_q <= 1'b0;
      locked_q    <= 1'b0;
    end else begin
      match_q     <= match_d;
      have_prev_q <= have_prev_d;
      locked_q    <= locked_d;
    end
  end

  assign locked = locked_q;
`else
  assign locked = 1'b0;
`endif

endmodule : clock_divider_meter

// File: tb/tb_clock_divider_meter.sv
// Self-checking bench for clock_divider_meter. The reference model works on
// cycle timestamps of detected inClk edges rather than on a counter.
module tb_clock_divider_meter;

  localparam int CNT_W  = 32;
  localparam int MAXC   = 100;
  localparam int LOCK_N = 4;
`ifdef CLOCK_DIVIDER_METER_LOCK_DETECT_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic             clk    = 1'b0;
  logic             reset  = 1'b1;
  logic             inClk  = 1'b0;
  logic             enable = 1'b0;
  logic [CNT_W-1:0] measCount;
  logic             measValid;
  logic             timeout;
  logic             locked;

  clock_divider_meter #(
    .CNT_W     (CNT_W),
    .MAX_COUNT (32'd100),
    .LOCK_N    (LOCK_N)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .inClk     (inClk),
    .enable    (enable),
    .measCount (measCount),
    .measValid (measValid),
    .timeout   (timeout),
    .locked    (locked)
  );

  always #5 clk = ~clk;

  wire [CNT_W+2:0] obs_w = {measValid, timeout, locked, measCount};

  // Reference model state
  int               cyc    = 0;
  int               m_mode = 0;   // 0 idle, 1 waiting for first edge, 2 measuring
  int               m_last = 0;   // cycle of the last detected edge
  bit               d1, d2, d3;   // inClk as sampled 1..3 edges ago
  bit               exp_valid, exp_timeout, exp_locked;
  logic [CNT_W-1:0] exp_count;
  logic [CNT_W+2:0] exp_v;
  int               res_q[$];
  int               n_checks = 0;
  int               n_pass   = 0;

  function automatic bit last_n_equal();
    int sz;
    sz = res_q.size();
    if (sz < LOCK_N) return 1'b0;
    for (int i = 1; i < LOCK_N; i++) begin
      if (res_q[sz-1-i] != res_q[sz-1]) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_clear();
    m_mode = 0; d1 = 1'b0; d2 = 1'b0; d3 = 1'b0;
    exp_valid = 1'b0; exp_timeout = 1'b0; exp_locked = 1'b0;
    exp_count = '0;
    res_q.delete();
    exp_v = '0;
  endtask

  task automatic model_step();
    bit e;
    e  = d2 ^ d3;
    d3 = d2; d2 = d1; d1 = inClk;
    exp_valid = 1'b0;
    if (!enable) begin
      m_mode = 0;
      res_q.delete();
    end else if (m_mode == 0) begin
      m_mode = 1;
      exp_timeout = 1'b0;
      res_q.delete();
    end else if (m_mode == 1) begin
      if (e) begin
        m_mode = 2;
        m_last = cyc;
      end
    end else begin
      if (e) begin
        exp_valid = 1'b1;
        exp_count = CNT_W'(cyc - m_last);
        res_q.push_back(cyc - m_last);
        m_last = cyc;
      end else if ((cyc - m_last) == MAXC) begin
        exp_timeout = 1'b1;
        m_mode = 1;
        res_q.delete();
      end
    end
    exp_locked = LOCK_EN && last_n_equal();
  endtask

  // Advance one clock, update the model, and return #1 after the edge
  task automatic cycle();
    @(posedge clk);
    cyc++;
    if (reset) model_clear();
    else model_step();
    exp_v = {exp_valid, exp_timeout, exp_locked, exp_count};
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b0; inClk = 1'b0;
    repeat (3) cycle();
    n_checks++;
    if (obs_w !== '0) $display("FAIL reset_state got=%h want=0", obs_w);
    else n_pass++;
    reset = 1'b0;
    enable = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cycle();
      n_checks++;
      if (obs_w !== exp_v) $display("FAIL reset_release cyc=%0d got=%h want=%h", cyc, obs_w, exp_v);
      else n_pass++;
    end
  endtask

  task automatic test_basic_6();
    enable = 1'b1;
    for (int t = 0; t < 10; t++) begin
      inClk = ~inClk;
      for (int k = 0; k < 6; k++) begin
        cycle();
        n_checks++;
        if (obs_w !== exp_v) $display("FAIL basic_6 cyc=%0d got=%h want=%h", cyc, obs_w, exp_v);
        else n_pass++;
      end
    end
    n_checks++;
    if (measCount !== 32'd6 || timeout !== 1'b0)
      $display("FAIL basic_6_value got count=%0d timeout=%b want count=6 timeout=0", measCount, timeout);
    else n_pass++;
  endtask

  task automatic test_period_change();
    int hps[4] = '{6, 11, 16, 21};
    foreach (hps[h]) begin
      for (int t = 0; t < 4; t++) begin
        inClk = ~inClk;
        for (int k = 0; k < hps[h]; k++) begin
          cycle();
          n_checks++;
          if (obs_w !== exp_v) $display("FAIL period_change cyc=%0d got=%h want=%h", cyc, obs_w, exp_v);
          else n_pass++;
        end
      end
      n_checks++;
      if (measCount !== CNT_W'(hps[h]))
        $display("FAIL period_change_value got=%0d want=%0d", measCount, hps[h]);
      else n_pass++;
    end
  endtask

  task automatic test_timeout();
    for (int k = 0; k < 130; k++) begin
      cycle();
      n_checks++;
      if (obs_w !== exp_v) $display("FAIL timeout cyc=%0d got=%h want=%h", cyc, obs_w, exp_v);
      else n_pass++;
    end
    n_checks++;
    if (timeout !== 1'b1 || measCount !== 32'd21 || measValid !== 1'b0)
      $display("FAIL timeout_value got t=%b c=%0d v=%b want t=1 c=21 v=0", timeout, measCount, measValid);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int guard;
    enable = 1'b1;
    for (int t = 0; t < 2; t++) begin
      inClk = ~inClk;
      for (int k = 0; k < 60; k++) begin
        cycle();
        n_checks++;
        if (obs_w !== exp_v) $display("FAIL reset_mid_pre cyc=%0d got=%h want=%h", cyc, obs_w, exp_v);
        else n_pass++;
      end
    end
    inClk = ~inClk;
    guard = 0;
    while (!(m_mode == 2 && (cyc - m_last) == 49) && guard < 200) begin
      cycle();
      guard++;
    end
    n_checks++;
    if (guard >= 200) $display("FAIL reset_mid_reach got=%0d cycles want<200", guard);
    else n_pass++;
    #1 reset = 1'b1;
    #1;
    n_checks++;
    if (obs_w !== '0) $display("FAIL reset_mid_clear got=%h want=0", obs_w);
    else n_pass++;
    model_clear();
    inClk = 1'b0;
    repeat (2) cycle();
    reset = 1'b0;
    for (int t = 0; t < 5; t++) begin
      inClk = ~inClk;
      for (int k = 0; k < 7; k++) begin
        cycle();
        n_checks++;
        if (obs_w !== exp_v) $display("FAIL reset_mid_post cyc=%0d got=%h want=%h", cyc, obs_w, exp_v);
        else n_pass++;
      end
    end
  endtask

  task automatic test_lock();
    int hps[13] = '{10, 10, 10, 10, 10, 10, 9, 10, 10, 10, 10, 10, 10};
    enable = 1'b1;
    foreach (hps[h]) begin
      inClk = ~inClk;
      for (int k = 0; k < hps[h]; k++) begin
        cycle();
        n_checks++;
        if (obs_w !== exp_v) $display("FAIL lock cyc=%0d got=%h want=%h", cyc, obs_w, exp_v);
        else n_pass++;
      end
    end
    n_checks++;
    if (locked !== LOCK_EN) $display("FAIL lock_final got=%b want=%b", locked, LOCK_EN);
    else n_pass++;
  endtask

  task automatic test_random();
    int hp;
    int off;
    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(7, 0) == 0) begin
        enable = 1'b0;
        off = $urandom_range(3, 1);
        for (int k = 0; k < off; k++) begin
          cycle();
          n_checks++;
          if (obs_w !== exp_v) $display("FAIL random_off cyc=%0d got=%h want=%h", cyc, obs_w, exp_v);
          else n_pass++;
        end
        enable = 1'b1;
      end
      hp = $urandom_range(25, 1);
      inClk = ~inClk;
      for (int k = 0; k < hp; k++) begin
        cycle();
        n_checks++;
        if (obs_w !== exp_v) $display("FAIL random cyc=%0d got=%h want=%h", cyc, obs_w, exp_v);
        else n_pass++;
      end
    end
  endtask

  task automatic test_back_to_back();
    enable = 1'b1;
    for (int k = 0; k < 20; k++) begin
      inClk = ~inClk;
      cycle();
      n_checks++;
      if (obs_w !== exp_v) $display("FAIL back_to_back cyc=%0d got=%h want=%h", cyc, obs_w, exp_v);
      else n_pass++;
    end
    n_checks++;
    if (measValid !== 1'b1 || measCount !== 32'd1)
      $display("FAIL back_to_back_value got v=%b c=%0d want v=1 c=1", measValid, measCount);
    else n_pass++;
    enable = 1'b0;
    inClk = ~inClk;
    cycle();
    n_checks++;
    if (measValid !== 1'b0 || obs_w !== exp_v)
      $display("FAIL back_to_back_disable got=%h want=%h", obs_w, exp_v);
    else n_pass++;
    for (int k = 0; k < 4; k++) begin
      inClk = ~inClk;
      cycle();
      n_checks++;
      if (obs_w !== exp_v) $display("FAIL back_to_back_idle cyc=%0d got=%h want=%h", cyc, obs_w, exp_v);
      else n_pass++;
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_basic_6();
    test_period_change();
    test_timeout();
    test_reset_mid();
    test_lock();
    test_random();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_clock_divider_meter
